serial_addsub: RTL and testbench

Bit-serial two's-complement adder/subtractor for the ALU datapath. It accepts two WIDTH-bit operands on a start pulse and streams them LSB-first through a single one-bit full-adder cell, one bit per clock, with a registered carry between bits. It produces a WIDTH-bit result plus carry-out and signed-overflow flags. It trades latency for area and sits next to the one-bit full-adder cell, feeding it operand bits and consuming its sum and carry outputs.

---
 rtl/serial_addsub_pkg.sv | 19 +
 rtl/serial_addsub_if.sv | 28 ++
 rtl/serial_addsub_bfa.sv | 14 +
 rtl/serial_addsub.sv | 110 +++++++++++
 tb/tb_serial_addsub.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared ALU definitions for the bit-serial adder/subtractor:
// FSM state encoding (also used by the ALU control decoder) and default width.
package serial_addsub_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Operand B as presented to the adder: inverted for subtraction
    // (the +1 comes from the initial carry).
    function automatic logic [31:0] b_operand(input logic [31:0] b, input logic sub);
        return sub ? ~b : b;
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle of the bit-serial adder/subtractor.
// master: requester (start, sub, a, b out; busy, done, sum, cout, ovf in).
// slave:  the serial_addsub unit (directions reversed).
interface serial_addsub_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/serial_addsub_bfa.sv
// BFA: one-bit full-adder cell from the ALU library.
// Ports: a_i, b_i, c_i operand/carry bits in; s_o sum bit, c_o carry out.
module serial_addsub_bfa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, LSB first, one bit per clock.
// Ports: clk, rst (async, active-high); bus (slave) carries start/sub/a/b in
// and busy/done/sum/cout/ovf out. All outputs come straight from registers.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic            clk,
    input logic            rst,
    serial_addsub_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_c;
    logic [31:0] b_ext;

    serial_addsub_bfa u_bfa (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    assign b_ext = b_operand(32'(bus.b), bus.sub);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    a_sr_d  = bus.a;
                    b_sr_d  = b_ext[WIDTH-1:0];
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                if (cnt_q == LAST) begin
                    // carry_q is the carry into the MSB at this point
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH=8).
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_serial_addsub;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t_done1;
    int   t_done2;
    logic seen_done;

    serial_addsub_if #(.WIDTH(W)) bus_if ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bus_if.start = 1'b1;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.sub   = s;
        step();
        bus_if.start = 1'b0;
        chk("accept_busy", 32'(bus_if.busy), 32'd1);
        chk("accept_sum_clr", 32'(bus_if.sum), 32'd0);
    endtask

    // k = RUN cycles already stepped through after launch
    task automatic finish(input string tag, input int k, input logic [W-1:0] es,
                          input logic ec, input logic eo);
        logic early;
        early = 1'b0;
        for (int i = k; i < W - 1; i++) begin
            step();
            if (bus_if.done || !bus_if.busy) early = 1'b1;
        end
        chk({tag, "_no_early_done"}, 32'(early), 32'd0);
        step();
        chk({tag, "_done"}, 32'(bus_if.done), 32'd1);
        chk({tag, "_busy_low"}, 32'(bus_if.busy), 32'd0);
        chk({tag, "_sum"}, 32'(bus_if.sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus_if.cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus_if.ovf), 32'(eo));
    endtask

    initial begin
        bus_if.start = 1'b0;
        bus_if.sub   = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        #1;
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_sum", 32'(bus_if.sum), 32'd0);
        chk("rst_cout", 32'(bus_if.cout), 32'd0);
        chk("rst_ovf", 32'(bus_if.ovf), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        launch(8'h5A, 8'h3C, 1'b0);
        finish("add5a3c", 0, 8'h96, 1'b0, 1'b1);
        step();
        chk("done_one_cycle", 32'(bus_if.done), 32'd0);
        chk("sum_held", 32'(bus_if.sum), 32'h96);

        launch(8'hFF, 8'h01, 1'b0);
        finish("addff01", 0, 8'h00, 1'b1, 1'b0);
        step();

        launch(8'h10, 8'h20, 1'b1);
        finish("sub1020", 0, 8'hF0, 1'b0, 1'b0);
        step();

        launch(8'h80, 8'h01, 1'b1);
        finish("sub8001", 0, 8'h7F, 1'b1, 1'b1);
        t_done1 = cyc;
        launch(8'h03, 8'h04, 1'b0);
        finish("b2b_add", 0, 8'h07, 1'b0, 1'b0);
        t_done2 = cyc;
        chk("b2b_spacing", 32'(t_done2 - t_done1), 32'd9);
        step();

        launch(8'h11, 8'h22, 1'b0);
        step();
        step();
        bus_if.start = 1'b1;
        bus_if.a     = 8'hFF;
        bus_if.b     = 8'hFF;
        bus_if.sub   = 1'b1;
        step();
        bus_if.start = 1'b0;
        finish("ignore_start", 3, 8'h33, 1'b0, 1'b0);
        step();

        launch(8'h5A, 8'h3C, 1'b0);
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus_if.busy), 32'd0);
        chk("midrst_done", 32'(bus_if.done), 32'd0);
        chk("midrst_sum", 32'(bus_if.sum), 32'd0);
        chk("midrst_cout", 32'(bus_if.cout), 32'd0);
        chk("midrst_ovf", 32'(bus_if.ovf), 32'd0);
        chk("midrst_state", 32'(dut.state_q), 32'd0);
        step();
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            step();
            if (bus_if.done) seen_done = 1'b1;
        end
        chk("midrst_no_done", 32'(seen_done), 32'd0);

        launch(8'h5A, 8'h3C, 1'b0);
        finish("after_rst", 0, 8'h96, 1'b0, 1'b1);
        step();
        chk("idle_after_done", 32'(bus_if.done | bus_if.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
